pe_injector: RTL and testbench

PE_INJECTOR -- requirements
Module: pe_injector

---
 rtl/noc_pkg.sv | 25 ++
 rtl/pe_injector_if.sv | 13 +
 rtl/noc_pkt_pack.sv | 34 +++
 rtl/pe_injector.sv | 159 +++++++++++++++
 tb/tb_pe_injector.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet field layout, end-of-burst marker and the
// injector FSM encoding used by PE traffic sources.
package noc_pkg;

    localparam int DATA_LSB = 0;
    localparam int DATA_W   = 9;
    localparam int SID_LSB  = 9;
    localparam int SID_W    = 6;
    localparam int PID_LSB  = 15;
    localparam int PID_W    = 10;
    localparam int DEST_LSB = 25;
    localparam int DEST_W   = 6;
    localparam int FIELD_W  = DEST_LSB + DEST_W;

    localparam logic [DATA_W-1:0] NOC_END_DATA = 9'h167;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_REQ  = 3'd2,
        ST_GAP  = 3'd3,
        ST_FIN  = 3'd4
    } inj_state_e;

endpackage

// File: rtl/pe_injector_if.sv
// Local-port link between a PE source and its router: packet, request,
// one-cycle grant and buffer-full backpressure.
interface pe_injector_if #(
    parameter int PKT_W = 56
);
    logic [PKT_W-1:0] PacketOut;
    logic             ReqDnStr;
    logic             GntDnStr;
    logic             DnStrFull;

    modport master (output PacketOut, output ReqDnStr, input GntDnStr, input DnStrFull);
    modport slave  (input PacketOut, input ReqDnStr, output GntDnStr, output DnStrFull);
endinterface

// File: rtl/noc_pkt_pack.sv
// Combinational packet assembly; the last packet of a burst carries the end
// marker and any ordinary payload that collides with it is zeroed.
module noc_pkt_pack
    import noc_pkg::*;
#(
    parameter logic [SID_W-1:0]  ROUTER_ID = 6'b010_010,
    parameter int                PKT_W     = 56,
    parameter logic [DATA_W-1:0] END_DATA  = NOC_END_DATA
) (
    input  logic [DEST_W-1:0] dest_i,
    input  logic [PID_W-1:0]  pid_i,
    input  logic              last_i,
    output logic [PKT_W-1:0]  pkt_o
);

    logic [DATA_W-1:0] data;

    always_comb begin
        data = pid_i[DATA_W-1:0];
        if (last_i)
            data = END_DATA;
        else if (pid_i[DATA_W-1:0] == END_DATA)
            data = '0;
    end

    always_comb begin
        pkt_o                        = '0;
        pkt_o[DEST_LSB +: DEST_W]    = dest_i;
        pkt_o[PID_LSB  +: PID_W]     = pid_i;
        pkt_o[SID_LSB  +: SID_W]     = ROUTER_ID;
        pkt_o[DATA_LSB +: DATA_W]    = data;
    end

endmodule

// File: rtl/pe_injector.sv
// PE burst injector: emits num_pkts packets to the router local port with a
// programmable idle gap, honouring backpressure and a one-cycle grant.
module pe_injector
    import noc_pkg::*;
#(
    parameter logic [SID_W-1:0]  ROUTER_ID = 6'b010_010,
    parameter int                PKT_W     = 56,
    parameter logic [DATA_W-1:0] END_DATA  = NOC_END_DATA
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [DEST_W-1:0]   dest_id,
    input  logic [PID_W-1:0]    num_pkts,
    input  logic [7:0]          gap,
    pe_injector_if.master       dn,
    output logic                busy,
    output logic                done,
    output logic [PID_W-1:0]    sent_cnt,
    output logic [15:0]         stall_cnt
);

    inj_state_e        state_q, state_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [PID_W-1:0]  num_q, num_d;
    logic [7:0]        gap_q, gap_d;
    logic [7:0]        gcnt_q, gcnt_d;
    logic [PID_W-1:0]  idx_q, idx_d;
    logic [PKT_W-1:0]  pkt_q, pkt_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [PID_W-1:0]  sent_q, sent_d;
    logic [15:0]       stall_q, stall_d;

    logic [PKT_W-1:0]  pkt_w;
    logic              last;

    assign last = (idx_q == num_q - 10'd1);

    noc_pkt_pack #(
        .ROUTER_ID (ROUTER_ID),
        .PKT_W     (PKT_W),
        .END_DATA  (END_DATA)
    ) u_pack (
        .dest_i (dest_q),
        .pid_i  (idx_q),
        .last_i (last),
        .pkt_o  (pkt_w)
    );

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        num_d   = num_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        idx_d   = idx_q;
        pkt_d   = pkt_q;
        req_d   = req_q;
        busy_d  = busy_q;
        done_d  = done_q;
        sent_d  = sent_q;
        stall_d = stall_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dest_d  = dest_id;
                    num_d   = num_pkts;
                    gap_d   = gap;
                    idx_d   = '0;
                    sent_d  = '0;
                    stall_d = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = (num_pkts == '0) ? ST_FIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!dn.DnStrFull) begin
                    pkt_d   = pkt_w;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Request drops on the grant edge itself so the router sees
                // exactly one request per packet; Full no longer matters here.
                if (dn.GntDnStr) begin
                    req_d  = 1'b0;
                    pkt_d  = '0;
                    sent_d = sent_q + 10'd1;
                    idx_d  = idx_q + 10'd1;
                    if (last) begin
                        state_d = ST_FIN;
                    end else if (gap_q != '0) begin
                        gcnt_d  = gap_q;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else if (stall_q != 16'hFFFF) begin
                    stall_d = stall_q + 16'd1;
                end
            end
            ST_GAP: begin
                if (gcnt_q <= 8'd1)
                    state_d = ST_LOAD;
                else
                    gcnt_d = gcnt_q - 8'd1;
            end
            ST_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            dest_q  <= '0;
            num_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            idx_q   <= '0;
            pkt_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sent_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            num_q   <= num_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            idx_q   <= idx_d;
            pkt_q   <= pkt_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sent_q  <= sent_d;
            stall_q <= stall_d;
        end
    end

    assign dn.PacketOut = pkt_q;
    assign dn.ReqDnStr  = req_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign sent_cnt     = sent_q;
    assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_pe_injector.sv
// Directed bench for pe_injector: single packet, gapped burst, backpressure,
// payload substitution, mid-burst reset and stall saturation.
module tb_pe_injector;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] dest_id;
    logic [9:0] num_pkts;
    logic [7:0] gap;
    logic       busy, done;
    logic [9:0] sent_cnt;
    logic [15:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    pe_injector_if #(.PKT_W(56)) dn ();

    pe_injector dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dest_id   (dest_id),
        .num_pkts  (num_pkts),
        .gap       (gap),
        .dn        (dn.master),
        .busy      (busy),
        .done      (done),
        .sent_cnt  (sent_cnt),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag, input int max);
        int n = 0;
        while (!dn.ReqDnStr && n < max) begin
            tick();
            n++;
        end
        chk(tag, {63'd0, dn.ReqDnStr}, 64'd1);
    endtask

    task automatic grant();
        dn.GntDnStr = 1'b1;
        tick();
        dn.GntDnStr = 1'b0;
    endtask

    task automatic launch(input logic [5:0] d, input logic [9:0] n, input logic [7:0] g);
        dest_id  = d;
        num_pkts = n;
        gap      = g;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        int hi;
        int n;
        int pid_err;
        int data_err;
        logic [55:0] held;
        logic [8:0]  exp_data [4];
        exp_data = '{9'h000, 9'h001, 9'h002, 9'h167};

        reset = 1'b0; start = 1'b0; dest_id = '0; num_pkts = '0; gap = '0;
        dn.GntDnStr = 1'b0; dn.DnStrFull = 1'b0;
        tick(); tick();
        chk("rst_req",   {63'd0, dn.ReqDnStr}, 64'd0);
        chk("rst_pkt",   {8'd0, dn.PacketOut}, 64'd0);
        chk("rst_busy",  {63'd0, busy}, 64'd0);
        chk("rst_done",  {63'd0, done}, 64'd0);
        chk("rst_sent",  {54'd0, sent_cnt}, 64'd0);
        chk("rst_stall", {48'd0, stall_cnt}, 64'd0);
        reset = 1'b1;

        // Single packet, grant withheld two cycles
        launch(6'b001_011, 10'd1, 8'd0);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        wait_req("t1_req", 5);
        chk("t1_pkt", {8'd0, dn.PacketOut},
            {8'd0, 25'd0, 6'b001_011, 10'd0, 6'b010_010, 9'h167});
        tick(); tick();
        chk("t1_held", {63'd0, dn.ReqDnStr}, 64'd1);
        grant();
        chk("t1_stall", {48'd0, stall_cnt}, 64'd2);
        chk("t1_req_drop", {63'd0, dn.ReqDnStr}, 64'd0);
        chk("t1_pkt_zero", {8'd0, dn.PacketOut}, 64'd0);
        chk("t1_sent", {54'd0, sent_cnt}, 64'd1);
        chk("t1_done_early", {63'd0, done}, 64'd0);
        tick();
        chk("t1_done", {63'd0, done}, 64'd1);
        chk("t1_busy_end", {63'd0, busy}, 64'd0);

        // Four packets with gap=3; grant-to-next-request spans 3 GAP cycles + LOAD
        launch(6'b100_001, 10'd4, 8'd3);
        chk("t2_done_clr", {63'd0, done}, 64'd0);
        for (int p = 0; p < 4; p++) begin
            wait_req($sformatf("t2_req%0d", p), 10);
            chk($sformatf("t2_pid%0d", p), {54'd0, dn.PacketOut[24:15]}, 64'(p));
            chk($sformatf("t2_data%0d", p), {55'd0, dn.PacketOut[8:0]}, {55'd0, exp_data[p]});
            grant();
            if (p < 3) begin
                n = 0;
                while (!dn.ReqDnStr && n < 20) begin
                    tick();
                    n++;
                end
                chk($sformatf("t2_space%0d", p), 64'(n), 64'd4);
            end
        end
        chk("t2_sent", {54'd0, sent_cnt}, 64'd4);
        tick();
        chk("t2_done", {63'd0, done}, 64'd1);

        // Backpressure in LOAD, Full during REQ, stray grant outside REQ
        dn.DnStrFull = 1'b1;
        launch(6'b000_111, 10'd2, 8'd0);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            hi += int'(dn.ReqDnStr);
        end
        chk("t3_full_noreq", 64'(hi), 64'd0);
        grant();
        chk("t3_stray_gnt", {54'd0, sent_cnt}, 64'd0);
        dn.DnStrFull = 1'b0;
        tick();
        chk("t3_req_after_full", {63'd0, dn.ReqDnStr}, 64'd1);
        dn.DnStrFull = 1'b1;
        tick(); tick(); tick();
        chk("t3_req_held", {63'd0, dn.ReqDnStr}, 64'd1);
        grant();
        tick(); tick(); tick();
        chk("t3_full_again", {63'd0, dn.ReqDnStr}, 64'd0);
        dn.DnStrFull = 1'b0;
        wait_req("t3_req2", 5);
        chk("t3_pid1", {54'd0, dn.PacketOut[24:15]}, 64'd1);
        grant();
        tick();
        chk("t3_sent", {54'd0, sent_cnt}, 64'd2);
        chk("t3_done", {63'd0, done}, 64'd1);

        // 400 packets: index 359 (=0x167) zeroed, last carries end marker
        launch(6'b010_101, 10'd400, 8'd0);
        pid_err = 0;
        data_err = 0;
        for (int p = 0; p < 400; p++) begin
            n = 0;
            while (!dn.ReqDnStr && n < 10) begin
                tick();
                n++;
            end
            if (!dn.ReqDnStr || dn.PacketOut[24:15] != 10'(p)) pid_err++;
            if (p == 359)
                chk("t4_data359", {55'd0, dn.PacketOut[8:0]}, 64'h000);
            else if (p == 399) begin
                chk("t4_data399", {55'd0, dn.PacketOut[8:0]}, 64'h167);
                chk("t4_not_done", {63'd0, done}, 64'd0);
            end else if (dn.PacketOut[8:0] != 9'(p))
                data_err++;
            grant();
        end
        chk("t4_pid_seq", 64'(pid_err), 64'd0);
        chk("t4_data_seq", 64'(data_err), 64'd0);
        tick();
        chk("t4_done", {63'd0, done}, 64'd1);
        chk("t4_sent", {54'd0, sent_cnt}, 64'd400);

        // Reset pulse while requesting packet 2 of 5
        launch(6'b011_011, 10'd5, 8'd0);
        for (int p = 0; p < 2; p++) begin
            wait_req($sformatf("t5_req%0d", p), 10);
            grant();
        end
        wait_req("t5_req2", 10);
        chk("t5_pid2", {54'd0, dn.PacketOut[24:15]}, 64'd2);
        #2 reset = 1'b0;
        #1;
        chk("t5_async_req", {63'd0, dn.ReqDnStr}, 64'd0);
        chk("t5_async_pkt", {8'd0, dn.PacketOut}, 64'd0);
        chk("t5_async_busy", {63'd0, busy}, 64'd0);
        reset = 1'b1;
        hi = 0;
        launch(6'b000_000, 10'd0, 8'd0);
        hi += int'(dn.ReqDnStr);
        chk("t5_first_start", {63'd0, busy}, 64'd1);
        tick();
        hi += int'(dn.ReqDnStr);
        chk("t5_done", {63'd0, done}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            hi += int'(dn.ReqDnStr);
        end
        chk("t5_no_req", 64'(hi), 64'd0);

        // Grant withheld 70000 cycles; a start while busy must be ignored
        launch(6'b110_001, 10'd3, 8'd0);
        wait_req("t6_req", 5);
        held = dn.PacketOut;
        for (int i = 0; i < 70000; i++) begin
            if (i == 100) begin
                dest_id  = 6'b111_111;
                num_pkts = 10'd9;
                gap      = 8'd5;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        chk("t6_stall_sat", {48'd0, stall_cnt}, 64'hFFFF);
        chk("t6_req_held", {63'd0, dn.ReqDnStr}, 64'd1);
        chk("t6_pkt_stable", {8'd0, dn.PacketOut},
            {8'd0, 25'd0, 6'b110_001, 10'd0, 6'b010_010, 9'h000});
        chk("t6_pkt_same", {8'd0, dn.PacketOut}, {8'd0, held});
        grant();
        wait_req("t6_req1", 5);
        chk("t6_dest1", {58'd0, dn.PacketOut[30:25]}, 64'b110_001);
        grant();
        wait_req("t6_req2", 5);
        chk("t6_last_data", {55'd0, dn.PacketOut[8:0]}, 64'h167);
        grant();
        tick();
        chk("t6_sent", {54'd0, sent_cnt}, 64'd3);
        chk("t6_done", {63'd0, done}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
